// File: rtl/booth_mult_radix2.sv
// Signed radix-2 Booth multiplier, fully streaming, one operand pair per clock.
// Define BOOTH_PIPE_EN to register the lower/upper partial-product sums (3-edge latency).
module booth_mult_radix2 #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      M,
  input  logic [WIDTH-1:0]      Q,
  output logic                  out_valid,
  output logic [2*WIDTH-1:0]    P
);

  logic                 v1;
  logic [WIDTH-1:0]     m_r;
  logic [WIDTH-1:0]     q_r;
  logic [2*WIDTH-1:0]   m_ext;
  logic [WIDTH:0]       q_ext;
  logic [2*WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0]   lo_sum;
  logic [2*WIDTH-1:0]   hi_sum;

  // Sign-extend before any negation so the most negative M stays exact.
  assign m_ext = {{WIDTH{m_r[WIDTH-1]}}, m_r};
  assign q_ext = {q_r, 1'b0};

  always_comb begin
    lo_sum = '0;
    hi_sum = '0;
    pp     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case ({q_ext[i+1], q_ext[i]})
        2'b01:   pp = m_ext;
        2'b10:   pp = -m_ext;
        default: pp = '0;
      endcase
      pp = pp << i;
      if (i < WIDTH / 2) lo_sum = lo_sum + pp;
      else               hi_sum = hi_sum + pp;
    end
  end

  // Data registers only load on valid so X on idle inputs never reaches P.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      m_r <= '0;
      q_r <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        m_r <= M;
        q_r <= Q;
      end
    end
  end

`ifdef BOOTH_PIPE_EN
  logic               v2;
  logic [2*WIDTH-1:0] lo_r;
  logic [2*WIDTH-1:0] hi_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      lo_r      <= '0;
      hi_r      <= '0;
      out_valid <= 1'b0;
      P         <= '0;
    end else begin
      v2        <= v1;
      out_valid <= v2;
      if (v1) begin
        lo_r <= lo_sum;
        hi_r <= hi_sum;
      end
      if (v2) P <= lo_r + hi_r;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      P         <= '0;
    end else begin
      out_valid <= v1;
      if (v1) P <= lo_sum + hi_sum;
    end
  end
`endif

endmodule

// File: tb/tb_booth_mult_radix2.sv
// Self-checking bench for booth_mult_radix2: directed table, gap/reset/latency sequences, random.
// Expected products come from plain signed integer multiplication scheduled by latency.
module tb_booth_mult_radix2;

  localparam int W = 8;
`ifdef BOOTH_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic [W-1:0]       m = '0;
  logic [W-1:0]       q = '0;
  logic               out_valid;
  logic [2*W-1:0]     p;

  booth_mult_radix2 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .M(m), .Q(q),
    .out_valid(out_valid), .P(p)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int prod;
  } exp_t;

  typedef struct {
    int a;
    int b;
    int prod;
  } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   edge_n = 0;
  int   last_p = 0;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", name, got, want, edge_n);
    end
  endtask

  function automatic int p_signed();
    logic signed [2*W-1:0] s;
    s = p;
    return int'(s);
  endfunction

  // Drive at negedge, clock one edge, then compare against the schedule at the next negedge.
  task automatic cycle(input logic v, input int a, input int b, input int want);
    exp_t e;
    in_valid = v;
    if (v) begin
      m = W'(a);
      q = W'(b);
    end else begin
      m = 'x;
      q = 'x;
    end
    @(posedge clk);
    edge_n++;
    if (v) begin
      e.due  = edge_n + LAT - 1;
      e.prod = want;
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
      chk("out_valid", int'(out_valid), 1);
      chk("product", p_signed(), exp_q[0].prod);
      last_p = exp_q[0].prod;
      void'(exp_q.pop_front());
    end else begin
      chk("out_valid_idle", int'(out_valid), 0);
      chk("p_hold", p_signed(), last_p);
    end
  endtask

  initial begin
    vec_t tbl[8];
    int   edges;
    int   ra, rb;

    tbl[0] = '{10, 5, 50};
    tbl[1] = '{-12, 3, -36};
    tbl[2] = '{7, -4, -28};
    tbl[3] = '{-8, -8, 64};
    tbl[4] = '{-128, -128, 16384};
    tbl[5] = '{-128, 127, -16256};
    tbl[6] = '{127, 127, 16129};
    tbl[7] = '{0, -1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_p", p_signed(), 0);
    chk("reset_ov", int'(out_valid), 0);
    rst_n = 1'b1;

    // Back-to-back directed vectors; contiguous out_valid is checked per cycle.
    for (int i = 0; i < 8; i++) cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].prod);
    repeat (LAT + 1) cycle(1'b0, 0, 0, 0);

    // Gap pattern 1,0,1.
    cycle(1'b1, 3, 3, 9);
    cycle(1'b0, 0, 0, 0);
    cycle(1'b1, 4, 4, 16);
    repeat (LAT + 1) cycle(1'b0, 0, 0, 0);

    // Reset mid-flight: 25 must never appear.
    cycle(1'b1, 5, 5, 25);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_p", p_signed(), 0);
    chk("midreset_ov", int'(out_valid), 0);
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    last_p = 0;
    repeat (LAT + 2) cycle(1'b0, 0, 0, 0);

    // Latency: count edges from capture to out_valid.
    in_valid = 1'b1;
    m = W'(6);
    q = W'(7);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && edges < 10) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("latency_edges", edges, LAT);
    chk("latency_p", p_signed(), 42);
    edge_n += edges;
    last_p = 42;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    chk("latency_ov_pulse", int'(out_valid), 0);

    // Random stream with random gaps.
    for (int i = 0; i < 1000; i++) begin
      ra = $signed(W'($urandom));
      rb = $signed(W'($urandom));
      if ($urandom_range(3, 0) != 0) cycle(1'b1, ra, rb, ra * rb);
      else                           cycle(1'b0, 0, 0, 0);
    end
    repeat (LAT + 1) cycle(1'b0, 0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
